// File: rtl/pwm_bank_pkg.sv
// Register map, control bit positions and the per-channel compare helper
// shared by the PWM bank.
package pwm_bank_pkg;

    localparam int EN_OUT_BASE = 'h00;
    localparam int EN_PWM_BASE = 'h04;
    localparam int CTRL_ADDR   = 'h08;
    localparam int PRESC_ADDR  = 'h09;
    localparam int TOP_ADDR    = 'h0A;
    localparam int DUTY_BASE   = 'h10;

    localparam int CTRL_RUN    = 0;
    localparam int CTRL_CENTRE = 1;
    localparam int CTRL_FORCE  = 2;

    // Zero duty is always off; duty at or above TOP is always on.
    function automatic logic duty_cmp(input logic [7:0] cnt,
                                      input logic [7:0] duty,
                                      input logic [7:0] top);
        return (duty != 8'd0) && ((duty >= top) || (cnt < duty));
    endfunction

endpackage

// File: rtl/pwm_bank_timebase.sv
// Prescaler plus edge/centre-aligned period counter; flags the tick on which
// the counter returns to zero.
module pwm_timebase (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       centre,
    input  logic [7:0] top_act,
    input  logic [7:0] presc_act,
    input  logic       restart,
    output logic [7:0] cnt,
    output logic       boundary
);

    logic [7:0] psc;
    logic       down;
    logic       tick;
    logic [7:0] cnt_next;
    logic       down_next;

    always_comb begin
        tick      = run && !restart && (psc >= presc_act);
        cnt_next  = cnt;
        down_next = down;
        if (!centre) begin
            cnt_next  = (cnt >= top_act) ? 8'd0 : cnt + 8'd1;
            down_next = 1'b0;
        end else if (!down) begin
            // Turn at TOP without repeating it; TOP = 0 degenerates to a constant 0.
            if (cnt >= top_act) begin
                cnt_next  = (top_act == 8'd0) ? 8'd0 : top_act - 8'd1;
                down_next = 1'b1;
            end else begin
                cnt_next = cnt + 8'd1;
            end
        end else begin
            cnt_next = (cnt == 8'd0) ? 8'd0 : cnt - 8'd1;
        end
        if (cnt_next == 8'd0) begin
            down_next = 1'b0;
        end
        boundary = tick && (cnt_next == 8'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc  <= 8'd0;
            cnt  <= 8'd0;
            down <= 1'b0;
        end else if (!run || restart) begin
            psc  <= 8'd0;
            cnt  <= 8'd0;
            down <= 1'b0;
        end else begin
            psc <= (psc >= presc_act) ? 8'd0 : psc + 8'd1;
            if (tick) begin
                cnt  <= cnt_next;
                down <= down_next;
            end
        end
    end

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM bank: register file written from the SPI port, staged
// copies that reload at period boundaries, per-channel comparators and output mux.
module pwm_bank
    import pwm_bank_pkg::*;
#(
    parameter int         NUM_CH    = 16,
    parameter int         ADDR_W    = 7,
    parameter logic [7:0] RESET_TOP = 8'hFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    output logic [NUM_CH-1:0] out,
    output logic              period_start
);

    int                addr;
    logic [NUM_CH-1:0] en_out;
    logic [NUM_CH-1:0] en_pwm;
    logic              stg_run;
    logic              stg_centre;
    logic [7:0]        stg_presc;
    logic [7:0]        stg_top;
    logic [7:0]        stg_duty [NUM_CH];
    logic              act_run;
    logic              act_centre;
    logic [7:0]        act_presc;
    logic [7:0]        act_top;
    logic [7:0]        act_duty [NUM_CH];
    logic              force_upd;
    logic              load;
    logic              boundary;
    logic [7:0]        cnt;
    logic [NUM_CH-1:0] pwm;

    assign addr      = 32'(wr_addr);
    assign force_upd = wr_en && (addr == CTRL_ADDR) && wr_data[CTRL_FORCE];
    // While stopped the active copies simply follow staging.
    assign load      = boundary || !act_run || force_upd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_out     <= '0;
            en_pwm     <= '0;
            stg_run    <= 1'b1;
            stg_centre <= 1'b0;
            stg_presc  <= 8'd0;
            stg_top    <= RESET_TOP;
            for (int i = 0; i < NUM_CH; i++) stg_duty[i] <= 8'd0;
        end else if (wr_en) begin
            for (int k = 0; k < NUM_CH / 8; k++) begin
                if (addr == EN_OUT_BASE + k) en_out[8*k +: 8] <= wr_data;
                if (addr == EN_PWM_BASE + k) en_pwm[8*k +: 8] <= wr_data;
            end
            if (addr == CTRL_ADDR) begin
                stg_run    <= wr_data[CTRL_RUN];
                stg_centre <= wr_data[CTRL_CENTRE];
            end
            if (addr == PRESC_ADDR) stg_presc <= wr_data;
            if (addr == TOP_ADDR)   stg_top   <= wr_data;
            for (int i = 0; i < NUM_CH; i++) begin
                if (addr == DUTY_BASE + i) stg_duty[i] <= wr_data;
            end
        end
    end

    // Active copies read staging before this edge's write lands, so a write
    // coinciding with a boundary waits for the following one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_run      <= 1'b1;
            act_centre   <= 1'b0;
            act_presc    <= 8'd0;
            act_top      <= RESET_TOP;
            for (int i = 0; i < NUM_CH; i++) act_duty[i] <= 8'd0;
            period_start <= 1'b0;
        end else begin
            period_start <= boundary || (force_upd && wr_data[CTRL_RUN]);
            if (load) begin
                act_presc <= stg_presc;
                act_top   <= stg_top;
                for (int i = 0; i < NUM_CH; i++) act_duty[i] <= stg_duty[i];
                if (force_upd) begin
                    act_run    <= wr_data[CTRL_RUN];
                    act_centre <= wr_data[CTRL_CENTRE];
                end else begin
                    act_run    <= stg_run;
                    act_centre <= stg_centre;
                end
            end
        end
    end

    pwm_timebase u_timebase (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (act_run),
        .centre    (act_centre),
        .top_act   (act_top),
        .presc_act (act_presc),
        .restart   (force_upd),
        .cnt       (cnt),
        .boundary  (boundary)
    );

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign pwm[i] = act_run && duty_cmp(cnt, act_duty[i], act_top);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
        end else begin
            out <= en_out & (~en_pwm | pwm);
        end
    end

endmodule

// File: tb/tb_pwm_bank.sv
// Directed bench for pwm_bank: expectations are queued as each step is driven
// and popped when the measured DUT behaviour is available.
module tb_pwm_bank;
    import pwm_bank_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [6:0]  wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic [15:0] out;
    logic        period_start;

    int    n_assert = 0;
    int    n_fail = 0;
    string tag_q[$];
    int    exp_q[$];

    pwm_bank #(.NUM_CH(16), .ADDR_W(7), .RESET_TOP(8'hFF)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .out          (out),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    task automatic wr(input int a, input logic [7:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 7'(a);
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic push(input string t, input int v);
        tag_q.push_back(t);
        exp_q.push_back(v);
    endtask

    task automatic check(input logic [31:0] obs);
        string t;
        int    v;
        n_assert++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL sb_underflow: observed %0d, required a queued expectation", obs);
        end else begin
            t = tag_q.pop_front();
            v = exp_q.pop_front();
            assert (obs === 32'(v)) else begin
                n_fail++;
                $error("FAIL %s: observed %0d, required %0d", t, obs, v);
            end
        end
    endtask

    // Samples one period starting after a period_start sample, optionally
    // issuing a single write at sample number wr_at.
    task automatic run_period(input int ch, input int wr_at, input int a, input logic [7:0] d,
                              output int high, output int len, output logic [63:0] bits);
        high = 0;
        len  = 0;
        bits = '0;
        do begin
            @(negedge clk);
            if (len < 64) bits[len] = out[ch];
            len++;
            high += out[ch] ? 1 : 0;
            if (len == wr_at) begin
                wr_en   = 1'b1;
                wr_addr = 7'(a);
                wr_data = d;
            end
            if (len == wr_at + 1) wr_en = 1'b0;
        end while (!period_start && len < 2000);
    endtask

    task automatic wait_ps();
        int n = 0;
        while (!period_start && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!period_start) begin
            n_assert++;
            n_fail++;
            $error("FAIL ps_timeout: observed no period_start in %0d cycles, required one", n);
        end
    endtask

    task automatic measure(input int ch, output int high, output int len, output logic [63:0] bits);
        wait_ps();
        run_period(ch, -1, 0, 8'h00, high, len, bits);
    endtask

    initial begin
        int          h;
        int          l;
        logic [63:0] b;
        int          bad;
        int          ps_cnt;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state and static enables
        repeat (4) @(negedge clk);
        push("reset_out", 0);            check(32'(out));
        push("reset_ps", 0);             check(32'(period_start));
        wr(EN_OUT_BASE, 8'hFF);
        push("en_out_lag", 0);           check(32'(out));
        @(negedge clk);
        push("en_out_lo", 'h00FF);       check(32'(out));
        wr(EN_OUT_BASE + 1, 8'hFF);
        @(negedge clk);
        push("en_out_all", 'hFFFF);      check(32'(out));
        wr(EN_PWM_BASE, 8'h01);

        // Edge mode, 50% duty, TOP 0xFF
        wr(DUTY_BASE, 8'h80); wr(TOP_ADDR, 8'hFF); wr(PRESC_ADDR, 8'h00); wr(CTRL_ADDR, 8'h05);
        push("edge_len", 256); push("edge_high", 128);
        measure(0, h, l, b);             check(32'(l)); check(32'(h));
        push("static_hi", 'h7FFF);       check(32'(out[15:1]));

        // Prescaler and TOP, plus duty extremes
        wr(PRESC_ADDR, 8'd3); wr(TOP_ADDR, 8'd9); wr(DUTY_BASE, 8'd5); wr(CTRL_ADDR, 8'h05);
        push("presc_len", 40); push("presc_high", 20);
        measure(0, h, l, b);             check(32'(l)); check(32'(h));
        wr(DUTY_BASE, 8'd0); wr(CTRL_ADDR, 8'h05);
        push("duty0_len", 40); push("duty0_high", 0);
        measure(0, h, l, b);             check(32'(l)); check(32'(h));
        wr(DUTY_BASE, 8'd9); wr(CTRL_ADDR, 8'h05);
        push("dutytop_high", 40);
        measure(0, h, l, b);             check(32'(h));

        // Centre mode: cnt 0,1,2,3,4,3,2,1
        wr(PRESC_ADDR, 8'd0); wr(TOP_ADDR, 8'd4); wr(DUTY_BASE, 8'd2); wr(CTRL_ADDR, 8'h07);
        push("centre_len", 8); push("centre_high", 3); push("centre_shape", 'h83);
        measure(0, h, l, b);             check(32'(l)); check(32'(h)); check(32'(b[7:0]));

        // Shadowed duty change mid-period
        wr(TOP_ADDR, 8'hFF); wr(DUTY_BASE, 8'h40); wr(CTRL_ADDR, 8'h05);
        push("shadow_len", 256); push("shadow_cur_high", 64);
        run_period(0, 50, DUTY_BASE, 8'hC0, h, l, b);
        check(32'(l)); check(32'(h));
        push("shadow_next_high", 192);
        run_period(0, -1, 0, 8'h00, h, l, b);  check(32'(h));

        // Write landing on the boundary edge is deferred a full period
        push("coll_cur_high", 192);
        run_period(0, 255, DUTY_BASE, 8'h20, h, l, b); check(32'(h));
        push("coll_deferred_high", 192);
        run_period(0, -1, 0, 8'h00, h, l, b);  check(32'(h));
        push("coll_applied_high", 32);
        run_period(0, -1, 0, 8'h00, h, l, b);  check(32'(h));

        // Forced reload applies staged TOP/DUTY at once
        wr(TOP_ADDR, 8'h0F); wr(DUTY_BASE, 8'h08); wr(CTRL_ADDR, 8'h05);
        push("force_ps", 1);             check(32'(period_start));
        push("force_len", 16); push("force_high", 8);
        run_period(0, -1, 0, 8'h00, h, l, b);  check(32'(l)); check(32'(h));

        // Stop mid-period: PWM channel low, static channels kept, no pulses
        repeat (5) @(negedge clk);
        wr(CTRL_ADDR, 8'h04);
        @(negedge clk);
        push("stop_out", 'hFFFE);        check(32'(out));
        bad = 0;
        ps_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (out !== 16'hFFFE) bad++;
            if (period_start) ps_cnt++;
        end
        push("stop_hold_bad", 0);        check(32'(bad));
        push("stop_ps_cnt", 0);          check(32'(ps_cnt));
        wr(CTRL_ADDR, 8'h01);
        push("resume_len", 16); push("resume_high", 8);
        measure(0, h, l, b);             check(32'(l)); check(32'(h));

        // Asynchronous reset between edges
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        push("rst_out_now", 0);          check(32'(out));
        push("rst_ps_now", 0);           check(32'(period_start));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        push("rst_out_hold", 0);         check(32'(out));
        wr(EN_OUT_BASE, 8'h01); wr(EN_PWM_BASE, 8'h01); wr(DUTY_BASE, 8'h80);
        push("rst_top_len", 256); push("rst_top_high", 128);
        measure(0, h, l, b);             check(32'(l)); check(32'(h));

        n_assert++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL sb_leftover: observed %0d pending, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
